// File: rtl/redun_mont_pkg.sv
// rtl/redun_mont_pkg.sv - shared types for the redundant Montgomery squaring host
package redun_mont_pkg;

   localparam int NUM_WRDS = 4;
   localparam int WRD_BITS = 16;

   typedef logic [NUM_WRDS*WRD_BITS-1:0] redun0_t;

   typedef enum logic [2:0] {
      IDLE,
      START,
      RUN,
      DONE,
      ERR
   } host_state_t;

endpackage

// File: rtl/redun_mont_host.sv
// rtl/redun_mont_host.sv - job sequencer feeding the squaring engine and collecting its result
module redun_mont_host
   import redun_mont_pkg::*;
#(
   parameter int ITER_W      = 64,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_job_val,
   output logic              o_job_rdy,
   input  redun0_t           i_job_sq,
   input  logic [ITER_W-1:0] i_job_iter,
   output logic              o_start,
   output redun0_t           o_sq_in,
   input  redun0_t           i_sq_out,
   input  logic              i_valid,
   input  logic              i_locked,
   output logic              o_res_val,
   input  logic              i_res_rdy,
   output redun0_t           o_res_sq,
   output logic [ITER_W-1:0] o_res_iter,
   output logic              o_res_err,
   output logic              o_busy
);

   localparam int                WD_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [ITER_W-1:0] ONE     = ITER_W'(1);

   host_state_t       r_state;
   host_state_t       w_state_nxt;
   logic [ITER_W-1:0] r_iter;
   logic [ITER_W-1:0] r_cnt;
   logic [WD_W-1:0]   r_wdog;
   logic              w_accept;
   logic              w_last;
   logic              w_timeout;

   assign w_accept  = (r_state == IDLE) & i_job_val & i_locked;
   assign w_last    = (r_cnt == r_iter - ONE);
   assign w_timeout = (r_wdog == WD_LAST);
   assign o_job_rdy = (r_state == IDLE) & i_locked;
   assign o_busy    = (r_state != IDLE);

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Lock loss outranks a completing result arriving in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (w_accept) w_state_nxt = (i_job_iter == '0) ? DONE : START;
         START: w_state_nxt = i_locked ? RUN : ERR;
         RUN: begin
            if (!i_locked)               w_state_nxt = ERR;
            else if (i_valid && w_last)  w_state_nxt = DONE;
            else if (!i_valid && w_timeout) w_state_nxt = ERR;
         end
         DONE, ERR: if (i_res_rdy) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_start    <= 1'b0;
         o_sq_in    <= '0;
         o_res_val  <= 1'b0;
         o_res_sq   <= '0;
         o_res_iter <= '0;
         o_res_err  <= 1'b0;
         r_iter     <= '0;
         r_cnt      <= '0;
         r_wdog     <= '0;
      end else begin
         o_start <= 1'b0;
         case (r_state)
            IDLE: if (w_accept) begin
               // Seeding the result with the initial value covers both zero-iteration
               // jobs and aborts before any result came back.
               o_sq_in    <= i_job_sq;
               o_res_sq   <= i_job_sq;
               o_res_iter <= '0;
               r_iter     <= i_job_iter;
               r_cnt      <= '0;
               if (i_job_iter == '0) o_res_val <= 1'b1;
               else                  o_start   <= 1'b1;
            end
            START: begin
               r_cnt  <= '0;
               r_wdog <= '0;
               if (!i_locked) begin
                  o_res_val  <= 1'b1;
                  o_res_err  <= 1'b1;
                  o_res_iter <= '0;
               end
            end
            RUN: begin
               if (!i_locked) begin
                  o_res_val  <= 1'b1;
                  o_res_err  <= 1'b1;
                  o_res_iter <= r_cnt;
               end else if (i_valid) begin
                  r_cnt    <= r_cnt + ONE;
                  r_wdog   <= '0;
                  o_res_sq <= i_sq_out;
                  if (w_last) begin
                     o_res_val  <= 1'b1;
                     o_res_iter <= r_iter;
                  end
               end else if (w_timeout) begin
                  o_res_val  <= 1'b1;
                  o_res_err  <= 1'b1;
                  o_res_iter <= r_cnt;
               end else begin
                  r_wdog <= r_wdog + WD_W'(1);
               end
            end
            DONE, ERR: if (i_res_rdy) begin
               o_res_val <= 1'b0;
               o_res_err <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
